// File: rtl/age_matrix_scheduler_pkg.sv
`timescale 1ns/1ps
// sched_pkg: shared constants and index helpers for the age-matrix scheduler
// and the free-slot allocator it is built from.
package sched_pkg;

  localparam int DEFAULT_SLOTS    = 8;
  localparam int DEFAULT_INSERT_W = 3;

  // ceil(log2(value)), never below 1, so a one-entry index still gets a bit
  function automatic int clog2_min1(input int value);
    int result;
    result = 0;
    for (int w = 0; w < 31; w++) begin
      if ((64'd1 << w) < 64'(value)) result = w + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

  // Number of bits in the strict upper triangle of a slots x slots matrix
  function automatic int tri_bits(input int slots);
    return slots * (slots - 1) / 2;
  endfunction

  // Bit offset of pair (i, j), i < j, in the packed upper triangle.
  // Row i starts after rows 0..i-1, which hold (slots-1) + ... + (slots-i) bits.
  function automatic int tri_idx(input int i, input int j, input int slots);
    return i * slots - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/age_matrix_scheduler_if.sv
`timescale 1ns/1ps
// age_matrix_scheduler_if: handshake between fetch/decode, the execution
// slots and the age-matrix scheduler. The master side offers instructions,
// retires, flushes and requests; the slave side is the scheduler.
interface age_matrix_scheduler_if
  import sched_pkg::*;
#(
  parameter int SLOTS    = DEFAULT_SLOTS,
  parameter int INSERT_W = DEFAULT_INSERT_W
) ();

  localparam int CNT_W = $clog2(INSERT_W + 1);
  localparam int SRC_W = clog2_min1(INSERT_W);
  localparam int OCC_W = $clog2(SLOTS + 1);

  logic [CNT_W-1:0]       in_count;
  logic                   flush;
  logic [SLOTS-1:0]       slot_retire;
  logic [SLOTS-1:0]       req;

  logic [CNT_W-1:0]       in_accepted;
  logic [SLOTS-1:0]       slot_alloc;
  logic [SLOTS*SRC_W-1:0] slot_src;
  logic [SLOTS-1:0]       grant;
  // Row-major: older[i*SLOTS + j] set means slot i is older than slot j
  logic [SLOTS*SLOTS-1:0] older;
  logic [SLOTS-1:0]       valid;
  logic [OCC_W-1:0]       occupancy;

  modport master (
    output in_count, flush, slot_retire, req,
    input  in_accepted, slot_alloc, slot_src, grant, older, valid, occupancy
  );

  modport slave (
    input  in_count, flush, slot_retire, req,
    output in_accepted, slot_alloc, slot_src, grant, older, valid, occupancy
  );

endinterface

// File: rtl/age_matrix_scheduler_alloc.sv
`timescale 1ns/1ps
// free_slot_allocator: hands the first in_count offered items to the
// lowest-index free slots, in order. The k-th free slot (counting from
// index 0) takes item k. Purely combinational; shared with the load/store
// queue.
module free_slot_allocator
  import sched_pkg::*;
#(
  parameter  int SLOTS    = DEFAULT_SLOTS,
  parameter  int INSERT_W = DEFAULT_INSERT_W,
  localparam int CNT_W    = $clog2(INSERT_W + 1),
  localparam int SRC_W    = clog2_min1(INSERT_W)
) (
  input  logic [SLOTS-1:0]       free,
  input  logic [CNT_W-1:0]       in_count,
  output logic [SLOTS-1:0]       slot_alloc,
  output logic [SLOTS*SRC_W-1:0] slot_src,
  output logic [CNT_W-1:0]       in_accepted
);

  int free_total;

  assign free_total  = $countones(free);
  assign in_accepted = (free_total < int'(in_count)) ? CNT_W'(free_total) : in_count;

  // Each slot's rank is the number of free slots strictly below it; a free
  // slot whose rank is under the offered count takes the item with that rank.
  for (genvar gs = 0; gs < SLOTS; gs++) begin : g_slot
    localparam logic [SLOTS-1:0] BELOW = (SLOTS'(1) << gs) - SLOTS'(1);
    int rank;

    assign rank           = $countones(free & BELOW);
    assign slot_alloc[gs] = free[gs] && (rank < int'(in_count));
    assign slot_src[gs*SRC_W +: SRC_W] = slot_alloc[gs] ? SRC_W'(rank) : '0;
  end

endmodule

// File: rtl/age_matrix_scheduler.sv
`timescale 1ns/1ps
// age_matrix_scheduler: tracks SLOTS in-flight instructions with a relative
// age matrix, allocates up to INSERT_W new ones per cycle into free slots and
// grants the oldest valid requester. Only the strict upper triangle of the
// matrix is stored; the lower triangle is its inverse and the diagonal is 0.
module age_matrix_scheduler
  import sched_pkg::*;
#(
  parameter int SLOTS    = DEFAULT_SLOTS,
  parameter int INSERT_W = DEFAULT_INSERT_W
) (
  input  logic                  main_clk,
  input  logic                  main_rst_n,
  age_matrix_scheduler_if.slave bus
);

  localparam int CNT_W    = $clog2(INSERT_W + 1);
  localparam int SRC_W    = clog2_min1(INSERT_W);
  localparam int OCC_W    = $clog2(SLOTS + 1);
  localparam int TRI_BITS = tri_bits(SLOTS);

  logic [SLOTS-1:0]       valid_q;
  logic [SLOTS-1:0]       valid_d;
  logic [OCC_W-1:0]       occupancy_q;
  logic [OCC_W-1:0]       occupancy_d;
  logic [TRI_BITS-1:0]    upper_q;
  logic [TRI_BITS-1:0]    upper_d;

  logic [SLOTS*SLOTS-1:0] older_flat;
  logic [SLOTS-1:0]       older_row [SLOTS];
  logic [SLOTS-1:0]       free_slots;
  logic [SLOTS-1:0]       req_valid;
  logic [SLOTS-1:0]       grant_vec;

  logic [CNT_W-1:0]       offer_count;
  logic [SLOTS-1:0]       slot_alloc;
  logic [SLOTS*SRC_W-1:0] slot_src;
  logic [CNT_W-1:0]       in_accepted;

  // A flush accepts nothing, so the allocator simply sees an empty offer.
  // Slots retiring this cycle stay unavailable until the next one.
  assign free_slots  = ~valid_q;
  assign offer_count = bus.flush ? '0 : bus.in_count;

  free_slot_allocator #(
    .SLOTS    (SLOTS),
    .INSERT_W (INSERT_W)
  ) u_alloc (
    .free        (free_slots),
    .in_count    (offer_count),
    .slot_alloc  (slot_alloc),
    .slot_src    (slot_src),
    .in_accepted (in_accepted)
  );

  // Expand the stored triangle into the full matrix
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_row
    for (genvar gj = 0; gj < SLOTS; gj++) begin : g_col
      if (gi < gj) begin : g_upper
        assign older_flat[gi*SLOTS + gj] = upper_q[tri_idx(gi, gj, SLOTS)];
      end else if (gi > gj) begin : g_lower
        assign older_flat[gi*SLOTS + gj] = ~upper_q[tri_idx(gj, gi, SLOTS)];
      end else begin : g_diag
        assign older_flat[gi*SLOTS + gj] = 1'b0;
      end
    end
    assign older_row[gi] = older_flat[gi*SLOTS +: SLOTS];
  end

  // Next upper-triangle bit per pair: a newly allocated slot is younger than
  // any slot not allocated this cycle, two new slots order by source index,
  // and pairs with no new slot keep their relation.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_age_i
    for (genvar gj = gi + 1; gj < SLOTS; gj++) begin : g_age_j
      localparam int BIT = tri_idx(gi, gj, SLOTS);
      logic [SRC_W-1:0] src_i;
      logic [SRC_W-1:0] src_j;

      assign src_i = slot_src[gi*SRC_W +: SRC_W];
      assign src_j = slot_src[gj*SRC_W +: SRC_W];

      assign upper_d[BIT] = (slot_alloc[gi] && slot_alloc[gj]) ? (src_i < src_j) :
                            slot_alloc[gi]                     ? 1'b0            :
                            slot_alloc[gj]                     ? 1'b1            :
                                                                 upper_q[BIT];
    end
  end

  // Grant goes to the valid requester that is older than every other valid
  // requester; it only looks at registered state, never this cycle's updates.
  assign req_valid = bus.req & valid_q;

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_grant
    logic [SLOTS-1:0] wins;
    for (genvar gj = 0; gj < SLOTS; gj++) begin : g_vs
      if (gi == gj) begin : g_self
        assign wins[gj] = 1'b1;
      end else begin : g_other
        assign wins[gj] = ~req_valid[gj] | older_row[gi][gj];
      end
    end
    assign grant_vec[gi] = ~bus.flush & req_valid[gi] & (&wins);
  end

  // Occupancy next state: flush empties the window and overrides retires
  always_comb begin
    valid_d = '0;
    if (!bus.flush) begin
      valid_d = (valid_q & ~bus.slot_retire) | slot_alloc;
    end
    occupancy_d = OCC_W'($countones(valid_d));
  end

  // State registers; reset restores index order (lower index is older)
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      valid_q     <= '0;
      occupancy_q <= '0;
      upper_q     <= '1;
    end else begin
      valid_q     <= valid_d;
      occupancy_q <= occupancy_d;
      upper_q     <= upper_d;
    end
  end

  assign bus.in_accepted = in_accepted;
  assign bus.slot_alloc  = slot_alloc;
  assign bus.slot_src    = slot_src;
  assign bus.grant       = grant_vec;
  assign bus.older       = older_flat;
  assign bus.valid       = valid_q;
  assign bus.occupancy   = occupancy_q;

  // Interface contract and internal invariants
  a_count_legal: assert property (@(posedge main_clk) disable iff (!main_rst_n)
    int'(bus.in_count) <= INSERT_W);

  a_retire_valid: assert property (@(posedge main_clk) disable iff (!main_rst_n)
    (bus.slot_retire & ~valid_q) == '0);

  a_grant_onehot: assert property (@(posedge main_clk) disable iff (!main_rst_n)
    $onehot0(grant_vec));

  a_accept_count: assert property (@(posedge main_clk) disable iff (!main_rst_n)
    int'(in_accepted) == $countones(slot_alloc));

  // For valid i older than valid j, everything j is older than must also be
  // younger than i; antisymmetry holds for every off-diagonal pair.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_inv_i
    for (genvar gj = 0; gj < SLOTS; gj++) begin : g_inv_j
      if (gi != gj) begin : g_pair
        a_antisym: assert property (@(posedge main_clk) disable iff (!main_rst_n)
          older_row[gi][gj] != older_row[gj][gi]);

        a_transitive: assert property (@(posedge main_clk) disable iff (!main_rst_n)
          !(valid_q[gi] && valid_q[gj] && older_row[gi][gj]) ||
          ((older_row[gj] & valid_q & ~older_row[gi]) == '0));
      end
    end
  end

endmodule

// File: tb/tb_age_matrix_scheduler.sv
`timescale 1ns/1ps
// tb_age_matrix_scheduler: directed vectors with hand-computed expectations
// for the 8-slot, 3-wide configuration of the age-matrix scheduler.
module tb_age_matrix_scheduler;
  import sched_pkg::*;

  localparam int SLOTS    = 8;
  localparam int INSERT_W = 3;
  // Matrix right after reset: row i (byte i) has bits j > i set
  localparam logic [63:0] INDEX_ORDER = 64'h0080_C0E0_F0F8_FCFE;

  logic main_clk;
  logic main_rst_n;
  int   num_checks = 0;
  int   num_fails  = 0;

  age_matrix_scheduler_if #(.SLOTS(SLOTS), .INSERT_W(INSERT_W)) bus ();

  age_matrix_scheduler #(
    .SLOTS    (SLOTS),
    .INSERT_W (INSERT_W)
  ) dut (
    .main_clk   (main_clk),
    .main_rst_n (main_rst_n),
    .bus        (bus)
  );

  // 10 ns clock
  initial begin
    main_clk = 1'b0;
    forever #5 main_clk = ~main_clk;
  end

  // Safety net in case the sequence ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected sequence end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the falling edge, then let them settle
  task automatic applyStimulus(input logic [1:0] cnt, input logic fl,
                               input logic [7:0] ret, input logic [7:0] rq);
    @(negedge main_clk);
    bus.in_count    = cnt;
    bus.flush       = fl;
    bus.slot_retire = ret;
    bus.req         = rq;
    #1;
  endtask

  function automatic logic older_at(input int i, input int j);
    logic [63:0] t;
    t = bus.older >> (i * 8 + j);
    return t[0];
  endfunction

  function automatic logic [7:0] older_row_of(input int i);
    return 8'(bus.older >> (i * 8));
  endfunction

  function automatic logic [7:0] older_col_of(input int k);
    logic [7:0] col;
    col = 8'h00;
    for (int j = 0; j < 8; j++) col = col | (8'(older_at(j, k)) << j);
    return col;
  endfunction

  initial begin
    main_rst_n      = 1'b1;
    bus.in_count    = 2'd0;
    bus.flush       = 1'b0;
    bus.slot_retire = 8'h00;
    bus.req         = 8'h00;
    #1 main_rst_n   = 1'b0;
    #2;
    checkOutput("rst_valid",  64'(bus.valid),      64'h00);
    checkOutput("rst_occ",    64'(bus.occupancy),  64'h0);
    checkOutput("rst_older",  bus.older,           INDEX_ORDER);
    checkOutput("rst_grant",  64'(bus.grant),      64'h00);
    checkOutput("rst_alloc",  64'(bus.slot_alloc), 64'h00);
    @(negedge main_clk);
    main_rst_n = 1'b1;

    // First burst of three into an empty window
    applyStimulus(2'd3, 1'b0, 8'h00, 8'h00);
    checkOutput("a_acc",   64'(bus.in_accepted), 64'd3);
    checkOutput("a_alloc", 64'(bus.slot_alloc),  64'h07);
    checkOutput("a_src",   64'(bus.slot_src),    64'h0024);
    checkOutput("a_grant", 64'(bus.grant),       64'h00);
    applyStimulus(2'd0, 1'b0, 8'h00, 8'h00);
    checkOutput("b_valid", 64'(bus.valid),       64'h07);
    checkOutput("b_occ",   64'(bus.occupancy),   64'd3);
    checkOutput("b_o01",   64'(older_at(0, 1)),  64'd1);
    checkOutput("b_o12",   64'(older_at(1, 2)),  64'd1);
    checkOutput("b_o10",   64'(older_at(1, 0)),  64'd0);
    checkOutput("b_acc",   64'(bus.in_accepted), 64'd0);

    // Fill the window; the second burst is cut short to the two free slots
    applyStimulus(2'd3, 1'b0, 8'h00, 8'h00);
    checkOutput("c_alloc", 64'(bus.slot_alloc),  64'h38);
    checkOutput("c_src",   64'(bus.slot_src),    64'h0900);
    applyStimulus(2'd3, 1'b0, 8'h00, 8'h00);
    checkOutput("d_acc",   64'(bus.in_accepted), 64'd2);
    checkOutput("d_alloc", 64'(bus.slot_alloc),  64'hC0);
    checkOutput("d_src",   64'(bus.slot_src),    64'h4000);

    // Full window: a retire this cycle frees nothing until next cycle
    applyStimulus(2'd3, 1'b0, 8'h04, 8'h00);
    checkOutput("e_valid", 64'(bus.valid),       64'hFF);
    checkOutput("e_occ",   64'(bus.occupancy),   64'd8);
    checkOutput("e_acc",   64'(bus.in_accepted), 64'd0);
    checkOutput("e_alloc", 64'(bus.slot_alloc),  64'h00);
    applyStimulus(2'd3, 1'b0, 8'h00, 8'h00);
    checkOutput("f_valid", 64'(bus.valid),       64'hFB);
    checkOutput("f_occ",   64'(bus.occupancy),   64'd7);
    checkOutput("f_acc",   64'(bus.in_accepted), 64'd1);
    checkOutput("f_alloc", 64'(bus.slot_alloc),  64'h04);
    checkOutput("f_src",   64'(bus.slot_src),    64'h0000);
    applyStimulus(2'd0, 1'b0, 8'h00, 8'h00);
    checkOutput("g_valid", 64'(bus.valid),       64'hFF);
    checkOutput("g_col2",  64'(older_col_of(2)), 64'hFB);
    checkOutput("g_row2",  64'(older_row_of(2)), 64'h00);

    // Recycle slot 0 so it becomes the youngest; order is now 1,3,4,5,6,7,2,0
    applyStimulus(2'd0, 1'b0, 8'h01, 8'h00);
    applyStimulus(2'd1, 1'b0, 8'h00, 8'h00);
    checkOutput("i_valid", 64'(bus.valid),       64'hFE);
    checkOutput("i_alloc", 64'(bus.slot_alloc),  64'h01);
    applyStimulus(2'd0, 1'b0, 8'h00, 8'h81);
    checkOutput("j_grant", 64'(bus.grant),       64'h80);
    applyStimulus(2'd0, 1'b0, 8'h00, 8'h05);
    checkOutput("k_grant", 64'(bus.grant),       64'h04);
    applyStimulus(2'd0, 1'b0, 8'h00, 8'hFF);
    checkOutput("l_grant", 64'(bus.grant),       64'h02);

    // Grant and retire of the same slot in one cycle
    applyStimulus(2'd0, 1'b0, 8'h08, 8'h08);
    checkOutput("m_grant", 64'(bus.grant),       64'h08);
    applyStimulus(2'd0, 1'b0, 8'h00, 8'h08);
    checkOutput("n_grant", 64'(bus.grant),       64'h00);
    checkOutput("n_valid", 64'(bus.valid),       64'hF7);
    checkOutput("n_occ",   64'(bus.occupancy),   64'd7);

    // Drop to five valid slots, then flush with an offer and a retire pending
    applyStimulus(2'd0, 1'b0, 8'h30, 8'h00);
    applyStimulus(2'd2, 1'b1, 8'h01, 8'hFF);
    checkOutput("p_valid", 64'(bus.valid),       64'hC7);
    checkOutput("p_occ",   64'(bus.occupancy),   64'd5);
    checkOutput("p_acc",   64'(bus.in_accepted), 64'd0);
    checkOutput("p_alloc", 64'(bus.slot_alloc),  64'h00);
    checkOutput("p_grant", 64'(bus.grant),       64'h00);
    applyStimulus(2'd2, 1'b0, 8'h00, 8'h03);
    checkOutput("q_valid", 64'(bus.valid),       64'h00);
    checkOutput("q_occ",   64'(bus.occupancy),   64'd0);
    checkOutput("q_grant", 64'(bus.grant),       64'h00);
    checkOutput("q_acc",   64'(bus.in_accepted), 64'd2);
    checkOutput("q_alloc", 64'(bus.slot_alloc),  64'h03);
    checkOutput("q_src",   64'(bus.slot_src),    64'h0004);
    applyStimulus(2'd3, 1'b0, 8'h00, 8'h03);
    checkOutput("r_valid", 64'(bus.valid),       64'h03);
    checkOutput("r_occ",   64'(bus.occupancy),   64'd2);
    checkOutput("r_grant", 64'(bus.grant),       64'h01);
    checkOutput("r_o01",   64'(older_at(0, 1)),  64'd1);
    checkOutput("r_alloc", 64'(bus.slot_alloc),  64'h1C);

    // Refill, then make slot 0 youngest so reset has something to undo
    applyStimulus(2'd3, 1'b0, 8'h00, 8'h00);
    checkOutput("s_alloc", 64'(bus.slot_alloc),  64'hE0);
    applyStimulus(2'd0, 1'b0, 8'h01, 8'h00);
    applyStimulus(2'd1, 1'b0, 8'h00, 8'h00);
    checkOutput("u_alloc", 64'(bus.slot_alloc),  64'h01);
    applyStimulus(2'd0, 1'b0, 8'h00, 8'h00);
    checkOutput("v_valid", 64'(bus.valid),       64'hFF);
    checkOutput("v_row0",  64'(older_row_of(0)), 64'h00);
    checkOutput("v_col0",  64'(older_col_of(0)), 64'hFE);

    // Asynchronous reset in the middle of the high phase
    @(posedge main_clk);
    #3 main_rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", 64'(bus.valid),     64'h00);
    checkOutput("ar_occ",   64'(bus.occupancy), 64'd0);
    checkOutput("ar_older", bus.older,          INDEX_ORDER);
    bus.req = 8'hFF;
    #1;
    checkOutput("ar_grant", 64'(bus.grant),     64'h00);
    @(negedge main_clk);
    main_rst_n = 1'b1;

    applyStimulus(2'd1, 1'b0, 8'h00, 8'h00);
    checkOutput("w_alloc", 64'(bus.slot_alloc),  64'h01);
    checkOutput("w_acc",   64'(bus.in_accepted), 64'd1);
    applyStimulus(2'd0, 1'b0, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fails);
    $finish;
  end

endmodule
